// File: rtl/spike_window_classifier_pkg.sv
// Shared types and constants for the spike window classifier.
package spike_window_classifier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int clog2_f(input int val);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < val) res = i + 1;
      end
      return res;
   endfunction

   localparam int DEF_NUM_CLASSES = 10;
   localparam int DEF_CLASS_W = (clog2_f(DEF_NUM_CLASSES) < 1) ? 1 : clog2_f(DEF_NUM_CLASSES);

endpackage

// File: rtl/spike_window_classifier_sat_counter.sv
// Per-class spike counter: synchronous clear, increment enable, saturates at all-ones.
module spike_window_classifier_sat_counter
   import spike_window_classifier_pkg::*;
#(
   parameter int WIDTH_P = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [WIDTH_P-1:0] cnt_o
);

   logic [WIDTH_P-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH_P'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_window_classifier.sv
// Counts output-layer spikes over a fixed window, then scans for the winning class.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start_i; spikes ignored
// ST_COUNT | accumulating spike_i into per-class counters, WINDOW_LEN edges
// ST_SCAN  | one class per edge, running argmax with tie flag
// ST_DONE  | result valid, held until ready_i
module spike_window_classifier
   import spike_window_classifier_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH_P     = 8,
   parameter int WINDOW_LEN  = 64,
   parameter int CLASS_W     = DEF_CLASS_W
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [NUM_CLASSES-1:0] spike_i,
   input  logic                   ready_i,
   output logic                   busy_o,
   output logic                   valid_o,
   output logic [CLASS_W-1:0]     class_o,
   output logic [WIDTH_P-1:0]     max_count_o,
   output logic                   tie_o
);

   localparam int                 WIN_W    = $clog2(WINDOW_LEN + 1);
   localparam logic [WIN_W-1:0]   WIN_LOAD = WIN_W'(WINDOW_LEN - 1);
   localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

   state_t               state_d, state_q;
   logic [WIN_W-1:0]     win_d, win_q;
   logic [CLASS_W-1:0]   idx_d, idx_q;
   logic [WIDTH_P-1:0]   best_d, best_q;
   logic [CLASS_W-1:0]   cls_d, cls_q;
   logic                 tie_d, tie_q;
   logic [CLASS_W-1:0]   res_class_d, res_class_q;
   logic [WIDTH_P-1:0]   res_max_d, res_max_q;
   logic                 res_tie_d, res_tie_q;
   logic                 valid_d, valid_q;

   logic                   cnt_clr;
   logic [NUM_CLASSES-1:0] cnt_inc;
   logic [WIDTH_P-1:0]     cnt [NUM_CLASSES];
   logic [WIDTH_P-1:0]     cur_cnt;
   logic [WIDTH_P-1:0]     step_best;
   logic [CLASS_W-1:0]     step_cls;
   logic                   step_tie;

   for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
      spike_window_classifier_sat_counter #(
         .WIDTH_P (WIDTH_P)
      ) u_cnt (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .clr_i  (cnt_clr),
         .inc_i  (cnt_inc[k]),
         .cnt_o  (cnt[k])
      );
   end

   always_comb begin
      cur_cnt = '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
         if (idx_q == CLASS_W'(k)) cur_cnt = cnt[k];
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      step_best = best_q;
      step_cls  = cls_q;
      step_tie  = tie_q;
      if (idx_q == '0) begin
         step_best = cur_cnt;
         step_cls  = '0;
         step_tie  = 1'b0;
      end else if (cur_cnt > best_q) begin
         step_best = cur_cnt;
         step_cls  = idx_q;
         step_tie  = 1'b0;
      end else if (cur_cnt == best_q) begin
         step_tie  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      idx_d       = idx_q;
      best_d      = best_q;
      cls_d       = cls_q;
      tie_d       = tie_q;
      res_class_d = res_class_q;
      res_max_d   = res_max_q;
      res_tie_d   = res_tie_q;
      valid_d     = valid_q;
      cnt_clr     = 1'b0;
      cnt_inc     = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_COUNT;
               cnt_clr = 1'b1;
               win_d   = WIN_LOAD;
            end
         end
         ST_COUNT: begin
            cnt_inc = spike_i;
            if (win_q == '0) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end else begin
               win_d = win_q - WIN_W'(1);
            end
         end
         ST_SCAN: begin
            best_d = step_best;
            cls_d  = step_cls;
            tie_d  = step_tie;
            if (idx_q == LAST_IDX) begin
               state_d     = ST_DONE;
               valid_d     = 1'b1;
               res_class_d = step_cls;
               res_max_d   = step_best;
               res_tie_d   = step_tie;
            end else begin
               idx_d = idx_q + CLASS_W'(1);
            end
         end
         ST_DONE: begin
            if (ready_i) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         win_q       <= '0;
         idx_q       <= '0;
         best_q      <= '0;
         cls_q       <= '0;
         tie_q       <= 1'b0;
         res_class_q <= '0;
         res_max_q   <= '0;
         res_tie_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         idx_q       <= idx_d;
         best_q      <= best_d;
         cls_q       <= cls_d;
         tie_q       <= tie_d;
         res_class_q <= res_class_d;
         res_max_q   <= res_max_d;
         res_tie_q   <= res_tie_d;
         valid_q     <= valid_d;
      end
   end

   assign busy_o      = (state_q == ST_COUNT) || (state_q == ST_SCAN);
   assign valid_o     = valid_q;
   assign class_o     = res_class_q;
   assign max_count_o = res_max_q;
   assign tie_o       = res_tie_q;

endmodule
